// File: rtl/cot_lut_scheduler.sv
// Round-robin front end sharing one cotangent LUT between two requesters.
// Angles reduce to quadrant/offset; poles and out-of-range angles bypass the LUT.
module cot_lut_scheduler #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned LUT_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [DATA_WIDTH-1:0]   req_angle0,
  input  logic [DATA_WIDTH-1:0]   req_angle1,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_id,
  output logic                    rsp_err,
  output logic [2*DATA_WIDTH-1:0] rsp_data,
  output logic                    lut_en,
  output logic [1:0]              lut_quadrant,
  output logic [DATA_WIDTH-1:0]   lut_angle,
  input  logic [2*DATA_WIDTH-1:0] lut_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [DATA_WIDTH-1:0] D90  = DATA_WIDTH'(90);
  localparam logic [DATA_WIDTH-1:0] D180 = DATA_WIDTH'(180);
  localparam logic [DATA_WIDTH-1:0] D270 = DATA_WIDTH'(270);
  localparam logic [DATA_WIDTH-1:0] D360 = DATA_WIDTH'(360);

  state_t                    state_q, state_d;
  logic                      ptr_q;
  logic                      id_q;
  logic                      err_q;
  logic [1:0]                quad_q;
  logic [DATA_WIDTH-1:0]     ang_q;
  logic [3:0]                cnt_q;
  logic [2*DATA_WIDTH-1:0]   data_q;

  logic                      gnt_valid;
  logic                      gnt_id;
  logic [DATA_WIDTH-1:0]     sel_angle;
  logic [1:0]                red_q;
  logic [DATA_WIDTH-1:0]     red_r;
  logic                      red_err;

  // Grant and angle reduction, used only while IDLE
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = ptr_q;
    if (req_valid[ptr_q]) begin
      gnt_valid = 1'b1;
      gnt_id    = ptr_q;
    end else if (req_valid[~ptr_q]) begin
      gnt_valid = 1'b1;
      gnt_id    = ~ptr_q;
    end
    sel_angle = gnt_id ? req_angle1 : req_angle0;
    red_q     = 2'd0;
    red_r     = sel_angle;
    if (sel_angle < D90) begin
      red_q = 2'd0;
      red_r = sel_angle;
    end else if (sel_angle < D180) begin
      red_q = 2'd1;
      red_r = sel_angle - D90;
    end else if (sel_angle < D270) begin
      red_q = 2'd2;
      red_r = sel_angle - D180;
    end else if (sel_angle < D360) begin
      red_q = 2'd3;
      red_r = sel_angle - D270;
    end
    red_err = (sel_angle == '0) || (sel_angle == D180) || (sel_angle >= D360);
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_valid) state_d = red_err ? RESP : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && gnt_valid) req_ready[gnt_id] = 1'b1;
    lut_en       = (state_q == ISSUE);
    rsp_valid    = (state_q == RESP);
    rsp_id       = id_q;
    rsp_err      = err_q;
    rsp_data     = data_q;
    lut_quadrant = quad_q;
    lut_angle    = ang_q;
  end

  // Error requests leave the LUT operands untouched so the LUT sees no activity
  always_ff @(posedge clk) begin
    if (reset_n) begin
      ptr_q  <= 1'b0;
      id_q   <= 1'b0;
      err_q  <= 1'b0;
      quad_q <= '0;
      ang_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            id_q  <= gnt_id;
            ptr_q <= ~gnt_id;
            if (red_err) begin
              err_q  <= 1'b1;
              data_q <= '0;
            end else begin
              quad_q <= red_q;
              ang_q  <= red_r;
            end
          end
        end
        ISSUE: cnt_q <= 4'(LUT_LATENCY - 1);
        WAIT: begin
          if (cnt_q == '0) begin
            data_q <= lut_data;
            err_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cot_lut_scheduler.sv
// Bench for cot_lut_scheduler: behavioural LUT with fixed latency, vector table
// for reduction/poles, scoreboard queues for responses and LUT enables.
module tb_cot_lut_scheduler;

  localparam int LAT = 2;

  typedef struct {
    logic        id;
    logic        err;
    logic [63:0] data;
  } rsp_t;

  typedef struct {
    logic        id;
    logic [31:0] ang;
    logic [1:0]  q;
    logic [31:0] r;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_angle0, req_angle1;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [63:0] rsp_data;
  logic        lut_en;
  logic [1:0]  lut_quadrant;
  logic [31:0] lut_angle;
  logic [63:0] lut_data;

  int checks = 0;
  int errors = 0;

  rsp_t        rsp_q[$];
  logic [33:0] lut_q[$];
  logic [63:0] pipe [LAT];
  vec_t        vecs [13];

  cot_lut_scheduler #(.DATA_WIDTH(32), .LUT_LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_angle0(req_angle0), .req_angle1(req_angle1), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .lut_en(lut_en), .lut_quadrant(lut_quadrant), .lut_angle(lut_angle),
    .lut_data(lut_data)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] lutf(input logic [1:0] q, input logic [31:0] a);
    if (q == 2'd0 && a == 32'd30) return 64'h3FFBB67AE8584CAA;
    return {30'h1000_0000, q, a};
  endfunction

  // LUT model: result valid LAT edges after the edge sampling lut_en, junk otherwise
  always @(posedge clk) begin
    pipe[0] <= lut_en ? lutf(lut_quadrant, lut_angle) : 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign lut_data = pipe[LAT-1];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (!reset_n && rsp_valid && rsp_ready) begin
      if (rsp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected actual=id%0d expected=none", rsp_id);
      end else begin
        rsp_t e;
        e = rsp_q.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
        chk("rsp_data", rsp_data, e.data);
      end
    end
    if (!reset_n && lut_en) begin
      if (lut_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL lut_unexpected actual=%0h expected=none", {lut_quadrant, lut_angle});
      end else begin
        chk("lut_operands", 64'({lut_quadrant, lut_angle}), 64'(lut_q.pop_front()));
      end
    end
  end

  task automatic chk_zero(input string name);
    chk(name, 64'({req_ready, rsp_valid, rsp_id, rsp_err, lut_en, lut_quadrant}), 64'd0);
    chk({name, "_data"}, rsp_data, 64'd0);
    chk({name, "_angle"}, 64'(lut_angle), 64'd0);
  endtask

  task automatic single(input logic id, input logic [31:0] ang, input logic [1:0] eq,
                        input logic [31:0] er, input logic eerr);
    int n;
    rsp_t e;
    @(posedge clk); #1;
    if (id) req_angle1 = ang; else req_angle0 = ang;
    req_valid[id] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[id] && n < 20);
    chk("grant", 64'(req_ready), id ? 64'd2 : 64'd1);
    e.id = id; e.err = eerr; e.data = eerr ? 64'd0 : lutf(eq, er);
    rsp_q.push_back(e);
    if (!eerr) lut_q.push_back({eq, er});
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    n = 0;
    while (!rsp_valid && n < 30) begin @(posedge clk); #1; n++; end
    chk("latency", 64'(n), eerr ? 64'd0 : 64'(LAT + 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || lut_q.size() != 0) && n < 60) begin
      @(posedge clk); #1; n++;
    end
    chk("drain", 64'(rsp_q.size() + lut_q.size()), 64'd0);
  endtask

  task automatic arbitrate();
    int n;
    rsp_t e;
    @(posedge clk); #1;
    req_angle0 = 32'd45; req_angle1 = 32'd60; req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (req_ready == 2'b00 && n < 20);
      chk("arb_grant", 64'(req_ready), (k % 2) ? 64'd2 : 64'd1);
      e.id = logic'(k % 2); e.err = 1'b0;
      e.data = lutf(2'd0, (k % 2) ? 32'd60 : 32'd45);
      rsp_q.push_back(e);
      lut_q.push_back({2'd0, (k % 2) ? 32'd60 : 32'd45});
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    drain();
  endtask

  initial begin
    int n;
    rsp_t e;
    vecs[0]  = '{1'b0, 32'd30,         2'd0, 32'd30, 1'b0};
    vecs[1]  = '{1'b0, 32'd135,        2'd1, 32'd45, 1'b0};
    vecs[2]  = '{1'b1, 32'd225,        2'd2, 32'd45, 1'b0};
    vecs[3]  = '{1'b0, 32'd300,        2'd3, 32'd30, 1'b0};
    vecs[4]  = '{1'b1, 32'd90,         2'd1, 32'd0,  1'b0};
    vecs[5]  = '{1'b0, 32'd270,        2'd3, 32'd0,  1'b0};
    vecs[6]  = '{1'b0, 32'd0,          2'd0, 32'd0,  1'b1};
    vecs[7]  = '{1'b1, 32'd180,        2'd0, 32'd0,  1'b1};
    vecs[8]  = '{1'b0, 32'd360,        2'd0, 32'd0,  1'b1};
    vecs[9]  = '{1'b1, 32'd361,        2'd0, 32'd0,  1'b1};
    vecs[10] = '{1'b0, 32'hFFFF_FFFF,  2'd0, 32'd0,  1'b1};
    vecs[11] = '{1'b1, 32'd359,        2'd3, 32'd89, 1'b0};
    vecs[12] = '{1'b0, 32'd89,         2'd0, 32'd89, 1'b0};

    reset_n = 1'b1; req_valid = 2'b00; req_angle0 = '0; req_angle1 = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    chk_zero("reset");

    for (int i = 0; i < 13; i++)
      single(vecs[i].id, vecs[i].ang, vecs[i].q, vecs[i].r, vecs[i].err);
    drain();

    // Backpressure: response held, no grants, then exactly one handshake
    @(posedge clk); #1 rsp_ready = 1'b0;
    single(1'b1, 32'd45, 2'd0, 32'd45, 1'b0);
    req_angle0 = 32'd100; req_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_data", rsp_data, lutf(2'd0, 32'd45));
      chk("bp_ready", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_release_valid", 64'(rsp_valid), 64'd0);
    chk("bp_next_grant", 64'(req_ready), 64'd1);
    e.id = 1'b0; e.err = 1'b0; e.data = lutf(2'd1, 32'd10);
    rsp_q.push_back(e);
    lut_q.push_back({2'd1, 32'd10});
    @(posedge clk); #1 req_valid = 2'b00;
    drain();

    // Reset one edge after the lut_en pulse: in-flight result is dropped
    @(posedge clk); #1;
    req_angle0 = 32'd50; req_valid[0] = 1'b1;
    @(negedge clk);
    chk("mid_grant", 64'(req_ready), 64'd1);
    lut_q.push_back({2'd0, 32'd50});
    @(posedge clk); #1 req_valid = 2'b00;
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1 reset_n = 1'b0;
    @(negedge clk);
    chk_zero("mid_reset");
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    chk("mid_no_rsp", 64'(n), 64'd0);
    chk("mid_lut_consumed", 64'(lut_q.size()), 64'd0);

    arbitrate();
    single(1'b1, 32'd200, 2'd2, 32'd20, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
